cpu_ctrl_sequencer: RTL and testbench

//  Multi-cycle control sequencer for the 16-bit CPU core. Steps each instruction through

---
 rtl/cpu_ctrl_sequencer_pkg.sv | 28 ++
 rtl/cpu_ctrl_sequencer_if.sv | 47 ++++
 rtl/cpu_ctrl_sequencer_wait_timer.sv | 40 ++++
 rtl/cpu_ctrl_sequencer.sv | 171 +++++++++++++++++
 tb/tb_cpu_ctrl_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_sequencer_pkg
// Shared definitions for the multi-cycle control sequencer of the 16-bit CPU:
// state encodings, state/perf-counter widths and a small helper that tells
// which states sit on the memory handshake (and therefore run the wait timer).
// ---------------------------------------------------------------------------
package cpu_ctrl_sequencer_pkg;

    localparam int STATE_W = 3;
    localparam int PERF_W  = 32;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_REGREAD   = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    // States that hold O_mem_req and wait on I_mem_ready.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMORY);
    endfunction

endpackage

// File: rtl/cpu_ctrl_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_sequencer_if
// Bundles the sequencer's decoded-instruction inputs, memory handshake and
// datapath enable strobes.
//   master : the sequencer (drives O_*, reads I_*)
//   slave  : datapath / memory / environment (drives I_*, reads O_*)
// Signals:
//   I_halt_req, I_mem_ready, I_is_load, I_is_store, I_writes_rd  (to sequencer)
//   O_state[3], O_decode_en, O_reg_en, O_rD_write, O_alu_en, O_mem_req,
//   O_mem_we, O_pc_en, O_halted, O_fault, O_cycle_count[32], O_retired[32]
// ---------------------------------------------------------------------------
interface cpu_ctrl_sequencer_if;
    import cpu_ctrl_sequencer_pkg::*;

    logic               I_halt_req;
    logic               I_mem_ready;
    logic               I_is_load;
    logic               I_is_store;
    logic               I_writes_rd;
    logic [STATE_W-1:0] O_state;
    logic               O_decode_en;
    logic               O_reg_en;
    logic               O_rD_write;
    logic               O_alu_en;
    logic               O_mem_req;
    logic               O_mem_we;
    logic               O_pc_en;
    logic               O_halted;
    logic               O_fault;
    logic [PERF_W-1:0]  O_cycle_count;
    logic [PERF_W-1:0]  O_retired;

    modport master (
        input  I_halt_req, I_mem_ready, I_is_load, I_is_store, I_writes_rd,
        output O_state, O_decode_en, O_reg_en, O_rD_write, O_alu_en,
               O_mem_req, O_mem_we, O_pc_en, O_halted, O_fault,
               O_cycle_count, O_retired
    );

    modport slave (
        output I_halt_req, I_mem_ready, I_is_load, I_is_store, I_writes_rd,
        input  O_state, O_decode_en, O_reg_en, O_rD_write, O_alu_en,
               O_mem_req, O_mem_we, O_pc_en, O_halted, O_fault,
               O_cycle_count, O_retired
    );

endinterface

// File: rtl/cpu_ctrl_sequencer_wait_timer.sv
// ---------------------------------------------------------------------------
// ctrl_wait_timer
// Counts cycles spent waiting for memory ready and flags when the wait has
// reached MAX_COUNT. MAX_COUNT = 0 disables the timeout (O_expired stays 0).
// Ports:
//   I_clk      clock
//   I_reset    asynchronous active-high reset (counter -> 0)
//   I_clear    synchronous clear, takes priority over I_count
//   I_count    increment by one this cycle
//   O_expired  counter == MAX_COUNT (combinational from the counter)
// ---------------------------------------------------------------------------
module ctrl_wait_timer #(
    parameter int MAX_COUNT = 15
) (
    input  logic I_clk,
    input  logic I_reset,
    input  logic I_clear,
    input  logic I_count,
    output logic O_expired
);

    localparam int W = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;

    logic [W-1:0] count_q;

    // Wait counter: cleared whenever the sequencer changes state, so each
    // FETCH/MEMORY visit starts counting from zero.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            count_q <= '0;
        end else if (I_clear) begin
            count_q <= '0;
        end else if (I_count) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign O_expired = (MAX_COUNT != 0) && (count_q == W'(MAX_COUNT));

endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_sequencer
// Multi-cycle control sequencer for the 16-bit CPU core. Walks each
// instruction through FETCH/DECODE/REGREAD/EXECUTE/[MEMORY]/WRITEBACK and
// drives the decoder, register file, ALU, PC and memory-port enables. Handles
// the memory ready handshake with a bounded wait (-> FAULT), HALT and FAULT.
// Parameters:
//   MEM_WAIT_MAX  cycles a request may wait for ready before FAULT (0 = never)
// Ports:
//   I_clk    clock, all state on posedge
//   I_reset  asynchronous active-high reset (state -> HALT)
//   bus      cpu_ctrl_sequencer_if.master (decoded inputs, handshake, strobes)
// Configuration:
//   CTRL_PERF_COUNT_EN  defined: O_cycle_count / O_retired count (wrapping);
//                       undefined: both tied to 0, no counter flops.
// ---------------------------------------------------------------------------
module cpu_ctrl_sequencer
    import cpu_ctrl_sequencer_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                 I_clk,
    input  logic                 I_reset,
    cpu_ctrl_sequencer_if.master bus
);

    state_t state, next_state;
    logic   wait_clear, wait_count, wait_expired;

    logic decode_en_d, reg_en_d, rd_write_d, alu_en_d, mem_req_d, mem_we_d;
    logic pc_en_d, halted_d, fault_d;
    logic decode_en_q, reg_en_q, rd_write_q, alu_en_q, mem_req_q, mem_we_q;
    logic pc_en_q, halted_q, fault_q;

    ctrl_wait_timer #(.MAX_COUNT(MEM_WAIT_MAX)) u_wait_timer (
        .I_clk     (I_clk),
        .I_reset   (I_reset),
        .I_clear   (wait_clear),
        .I_count   (wait_count),
        .O_expired (wait_expired)
    );

    // State register; reset parks the core in HALT.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state <= S_HALT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Ready in the same cycle the timer expires wins.
    always_comb begin
        next_state = state;
        case (state)
            S_HALT:      if (!bus.I_halt_req) next_state = S_FETCH;
            S_FETCH: begin
                if (bus.I_mem_ready)       next_state = S_DECODE;
                else if (wait_expired)     next_state = S_FAULT;
            end
            S_DECODE:    next_state = S_REGREAD;
            S_REGREAD:   next_state = S_EXECUTE;
            S_EXECUTE:   next_state = (bus.I_is_load || bus.I_is_store) ? S_MEMORY : S_WRITEBACK;
            S_MEMORY: begin
                if (bus.I_mem_ready)       next_state = S_WRITEBACK;
                else if (wait_expired)     next_state = S_FAULT;
            end
            S_WRITEBACK: next_state = bus.I_halt_req ? S_HALT : S_FETCH;
            S_FAULT:     next_state = S_FAULT;
            default:     next_state = S_FAULT;
        endcase
    end

    // Any state change restarts the wait timer; it only advances while a
    // request is stalled in place.
    assign wait_clear = (next_state != state);
    assign wait_count = is_wait_state(state) && !bus.I_mem_ready && !wait_clear;

    // Strobes are decoded from next_state and registered, so they line up
    // exactly with the state register. A load+store instruction writes.
    always_comb begin
        decode_en_d = 1'b0;
        reg_en_d    = 1'b0;
        rd_write_d  = 1'b0;
        alu_en_d    = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        pc_en_d     = 1'b0;
        halted_d    = 1'b0;
        fault_d     = 1'b0;
        case (next_state)
            S_FETCH:     mem_req_d   = 1'b1;
            S_DECODE:    decode_en_d = 1'b1;
            S_REGREAD:   reg_en_d    = 1'b1;
            S_EXECUTE:   alu_en_d    = 1'b1;
            S_MEMORY: begin
                mem_req_d = 1'b1;
                mem_we_d  = bus.I_is_store;
            end
            S_WRITEBACK: begin
                pc_en_d    = 1'b1;
                reg_en_d   = bus.I_writes_rd;
                rd_write_d = bus.I_writes_rd;
            end
            S_HALT:      halted_d = 1'b1;
            S_FAULT:     fault_d  = 1'b1;
            default:     fault_d  = 1'b1;
        endcase
    end

    // Output registers; the async reset drops an in-flight O_mem_req at once.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            decode_en_q <= 1'b0;
            reg_en_q    <= 1'b0;
            rd_write_q  <= 1'b0;
            alu_en_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            pc_en_q     <= 1'b0;
            halted_q    <= 1'b1;
            fault_q     <= 1'b0;
        end else begin
            decode_en_q <= decode_en_d;
            reg_en_q    <= reg_en_d;
            rd_write_q  <= rd_write_d;
            alu_en_q    <= alu_en_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            pc_en_q     <= pc_en_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.O_state     = state;
    assign bus.O_decode_en = decode_en_q;
    assign bus.O_reg_en    = reg_en_q;
    assign bus.O_rD_write  = rd_write_q;
    assign bus.O_alu_en    = alu_en_q;
    assign bus.O_mem_req   = mem_req_q;
    assign bus.O_mem_we    = mem_we_q;
    assign bus.O_pc_en     = pc_en_q;
    assign bus.O_halted    = halted_q;
    assign bus.O_fault     = fault_q;

`ifdef CTRL_PERF_COUNT_EN
    logic [PERF_W-1:0] cycle_q, retired_q;

    // Perf counters: free-running cycle count and one retire per completed
    // WRITEBACK cycle; both wrap.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            if (state == S_WRITEBACK) begin
                retired_q <= retired_q + 1'b1;
            end
        end
    end

    assign bus.O_cycle_count = cycle_q;
    assign bus.O_retired     = retired_q;
`else
    assign bus.O_cycle_count = '0;
    assign bus.O_retired     = '0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl_sequencer
// Directed bench for cpu_ctrl_sequencer (MEM_WAIT_MAX = 4). Each test walks a
// hand-written table of expected states/strobes; inputs in a row are driven
// after that row is checked, i.e. they steer the following clock edge.
// Strobe vector order: {decode_en, reg_en, rD_write, alu_en, mem_req, mem_we,
// pc_en, halted, fault}.
// ---------------------------------------------------------------------------
module tb_cpu_ctrl_sequencer;
    import cpu_ctrl_sequencer_pkg::*;

    localparam logic [8:0] SB_HALT = 9'b000000010;
    localparam logic [8:0] SB_FET  = 9'b000010000;
    localparam logic [8:0] SB_DEC  = 9'b100000000;
    localparam logic [8:0] SB_RR   = 9'b010000000;
    localparam logic [8:0] SB_EX   = 9'b000100000;
    localparam logic [8:0] SB_MEMR = 9'b000010000;
    localparam logic [8:0] SB_MEMW = 9'b000011000;
    localparam logic [8:0] SB_WB   = 9'b000000100;
    localparam logic [8:0] SB_WBRD = 9'b011000100;
    localparam logic [8:0] SB_FLT  = 9'b000000001;

    // One table row: expected state/strobes, then inputs to drive afterwards.
    typedef struct packed {
        logic [2:0] st;
        logic [8:0] strb;
        logic       rdy;
        logic       hlt;
        logic       ld;
        logic       sto;
        logic       wr;
    } row_t;

    logic I_clk   = 1'b0;
    logic I_reset = 1'b1;
    int   errors  = 0;
    int   checks  = 0;

    cpu_ctrl_sequencer_if bus ();

    cpu_ctrl_sequencer #(.MEM_WAIT_MAX(4)) dut (
        .I_clk   (I_clk),
        .I_reset (I_reset),
        .bus     (bus)
    );

    always #5 I_clk = ~I_clk;

    function automatic logic [8:0] strobes();
        return {bus.O_decode_en, bus.O_reg_en, bus.O_rD_write, bus.O_alu_en,
                bus.O_mem_req, bus.O_mem_we, bus.O_pc_en, bus.O_halted, bus.O_fault};
    endfunction

    // Hold reset for two cycles with the given halt request, release on a negedge.
    task automatic reset_dut(input logic halt);
        I_reset            = 1'b1;
        bus.I_halt_req     = halt;
        bus.I_mem_ready    = 1'b0;
        bus.I_is_load      = 1'b0;
        bus.I_is_store     = 1'b0;
        bus.I_writes_rd    = 1'b0;
        @(negedge I_clk);
        @(negedge I_clk);
        I_reset = 1'b0;
    endtask

    task automatic test_reset();
        I_reset         = 1'b1;
        bus.I_halt_req  = 1'b1;
        bus.I_mem_ready = 1'b1;
        bus.I_is_load   = 1'b0;
        bus.I_is_store  = 1'b0;
        bus.I_writes_rd = 1'b0;
        @(negedge I_clk);
        @(negedge I_clk);
        checks++;
        if (bus.O_state !== 3'd6) begin
            errors++; $display("[TB] FAIL reset_state got %0d want 6", bus.O_state);
        end
        checks++;
        if (strobes() !== SB_HALT) begin
            errors++; $display("[TB] FAIL reset_strobes got %b want %b", strobes(), SB_HALT);
        end
        checks++;
        if (bus.O_cycle_count !== 32'd0 || bus.O_retired !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_perf got %0d/%0d want 0/0", bus.O_cycle_count, bus.O_retired);
        end
        I_reset = 1'b0;
        repeat (3) @(negedge I_clk);
        checks++;
        if (bus.O_state !== 3'd6 || strobes() !== SB_HALT) begin
            errors++; $display("[TB] FAIL halt_hold got %0d/%b want 6/%b", bus.O_state, strobes(), SB_HALT);
        end
    endtask

    task automatic test_alu_instr();
        row_t rows[7];
        rows = '{
            '{S_HALT,      SB_HALT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_FETCH,     SB_FET,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_DECODE,    SB_DEC,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_REGREAD,   SB_RR,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_EXECUTE,   SB_EX,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_WRITEBACK, SB_WBRD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_FETCH,     SB_FET,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1}
        };
        reset_dut(1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge I_clk);
            checks++;
            if (bus.O_state !== rows[i].st || strobes() !== rows[i].strb) begin
                errors++;
                $display("[TB] FAIL alu_instr row %0d: got %0d/%b want %0d/%b", i, bus.O_state, strobes(), rows[i].st, rows[i].strb);
            end
            {bus.I_mem_ready, bus.I_halt_req, bus.I_is_load, bus.I_is_store, bus.I_writes_rd} =
                {rows[i].rdy, rows[i].hlt, rows[i].ld, rows[i].sto, rows[i].wr};
        end
    endtask

    task automatic test_load_wait();
        row_t rows[10];
        rows = '{
            '{S_HALT,      SB_HALT, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
            '{S_FETCH,     SB_FET,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
            '{S_DECODE,    SB_DEC,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
            '{S_REGREAD,   SB_RR,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
            '{S_EXECUTE,   SB_EX,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1},
            '{S_MEMORY,    SB_MEMR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1},
            '{S_MEMORY,    SB_MEMR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1},
            '{S_MEMORY,    SB_MEMR, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
            '{S_WRITEBACK, SB_WBRD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
            '{S_FETCH,     SB_FET,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1}
        };
        reset_dut(1'b0);
        bus.I_is_load = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge I_clk);
            checks++;
            if (bus.O_state !== rows[i].st || strobes() !== rows[i].strb) begin
                errors++;
                $display("[TB] FAIL load_wait row %0d: got %0d/%b want %0d/%b", i, bus.O_state, strobes(), rows[i].st, rows[i].strb);
            end
            {bus.I_mem_ready, bus.I_halt_req, bus.I_is_load, bus.I_is_store, bus.I_writes_rd} =
                {rows[i].rdy, rows[i].hlt, rows[i].ld, rows[i].sto, rows[i].wr};
        end
    endtask

    // Plain store (no rD write), then a load+store that must behave as a store.
    task automatic test_store();
        row_t rows[14];
        rows = '{
            '{S_HALT,      SB_HALT, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
            '{S_FETCH,     SB_FET,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
            '{S_DECODE,    SB_DEC,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
            '{S_REGREAD,   SB_RR,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
            '{S_EXECUTE,   SB_EX,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
            '{S_MEMORY,    SB_MEMW, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
            '{S_WRITEBACK, SB_WB,   1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
            '{S_FETCH,     SB_FET,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
            '{S_DECODE,    SB_DEC,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
            '{S_REGREAD,   SB_RR,   1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
            '{S_EXECUTE,   SB_EX,   1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
            '{S_MEMORY,    SB_MEMW, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
            '{S_WRITEBACK, SB_WBRD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
            '{S_FETCH,     SB_FET,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1}
        };
        reset_dut(1'b0);
        bus.I_is_store = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge I_clk);
            checks++;
            if (bus.O_state !== rows[i].st || strobes() !== rows[i].strb) begin
                errors++;
                $display("[TB] FAIL store row %0d: got %0d/%b want %0d/%b", i, bus.O_state, strobes(), rows[i].st, rows[i].strb);
            end
            {bus.I_mem_ready, bus.I_halt_req, bus.I_is_load, bus.I_is_store, bus.I_writes_rd} =
                {rows[i].rdy, rows[i].hlt, rows[i].ld, rows[i].sto, rows[i].wr};
        end
    endtask

    // Ready withheld for 5 FETCH cycles -> sticky FAULT; then ready on the
    // 5th cycle -> DECODE with no fault.
    task automatic test_timeout();
        row_t rows_flt[9];
        row_t rows_ok[7];
        rows_flt = '{
            '{S_HALT,  SB_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_FETCH, SB_FET,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_FETCH, SB_FET,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_FETCH, SB_FET,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_FETCH, SB_FET,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_FETCH, SB_FET,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_FAULT, SB_FLT,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_FAULT, SB_FLT,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
            '{S_FAULT, SB_FLT,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1}
        };
        rows_ok = '{
            '{S_HALT,   SB_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_FETCH,  SB_FET,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_FETCH,  SB_FET,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_FETCH,  SB_FET,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_FETCH,  SB_FET,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_FETCH,  SB_FET,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_DECODE, SB_DEC,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1}
        };
        reset_dut(1'b0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge I_clk);
            checks++;
            if (bus.O_state !== rows_flt[i].st || strobes() !== rows_flt[i].strb) begin
                errors++;
                $display("[TB] FAIL timeout_fault row %0d: got %0d/%b want %0d/%b", i, bus.O_state, strobes(), rows_flt[i].st, rows_flt[i].strb);
            end
            {bus.I_mem_ready, bus.I_halt_req, bus.I_is_load, bus.I_is_store, bus.I_writes_rd} =
                {rows_flt[i].rdy, rows_flt[i].hlt, rows_flt[i].ld, rows_flt[i].sto, rows_flt[i].wr};
        end
        reset_dut(1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge I_clk);
            checks++;
            if (bus.O_state !== rows_ok[i].st || strobes() !== rows_ok[i].strb) begin
                errors++;
                $display("[TB] FAIL timeout_ready row %0d: got %0d/%b want %0d/%b", i, bus.O_state, strobes(), rows_ok[i].st, rows_ok[i].strb);
            end
            {bus.I_mem_ready, bus.I_halt_req, bus.I_is_load, bus.I_is_store, bus.I_writes_rd} =
                {rows_ok[i].rdy, rows_ok[i].hlt, rows_ok[i].ld, rows_ok[i].sto, rows_ok[i].wr};
        end
    endtask

    // Halt raised in EXECUTE: instruction completes, then HALT; drop -> FETCH.
    task automatic test_halt();
        row_t rows[9];
        rows = '{
            '{S_HALT,      SB_HALT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_FETCH,     SB_FET,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_DECODE,    SB_DEC,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_REGREAD,   SB_RR,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_EXECUTE,   SB_EX,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
            '{S_WRITEBACK, SB_WBRD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
            '{S_HALT,      SB_HALT, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
            '{S_HALT,      SB_HALT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{S_FETCH,     SB_FET,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1}
        };
        reset_dut(1'b0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge I_clk);
            checks++;
            if (bus.O_state !== rows[i].st || strobes() !== rows[i].strb) begin
                errors++;
                $display("[TB] FAIL halt row %0d: got %0d/%b want %0d/%b", i, bus.O_state, strobes(), rows[i].st, rows[i].strb);
            end
            {bus.I_mem_ready, bus.I_halt_req, bus.I_is_load, bus.I_is_store, bus.I_writes_rd} =
                {rows[i].rdy, rows[i].hlt, rows[i].ld, rows[i].sto, rows[i].wr};
        end
    endtask

    // Three back-to-back ALU instructions: third WB ends at cycle 15.
    task automatic test_back_to_back_perf();
        logic [31:0] exp_cycles, exp_retired;
`ifdef CTRL_PERF_COUNT_EN
        exp_cycles  = 32'd16;
        exp_retired = 32'd3;
`else
        exp_cycles  = 32'd0;
        exp_retired = 32'd0;
`endif
        reset_dut(1'b0);
        bus.I_mem_ready = 1'b1;
        bus.I_writes_rd = 1'b1;
        repeat (16) @(negedge I_clk);
        checks++;
        if (bus.O_state !== 3'd0) begin
            errors++; $display("[TB] FAIL perf_state got %0d want 0", bus.O_state);
        end
        checks++;
        if (bus.O_cycle_count !== exp_cycles) begin
            errors++; $display("[TB] FAIL perf_cycles got %0d want %0d", bus.O_cycle_count, exp_cycles);
        end
        checks++;
        if (bus.O_retired !== exp_retired) begin
            errors++; $display("[TB] FAIL perf_retired got %0d want %0d", bus.O_retired, exp_retired);
        end
    endtask

    // Reset asserted between edges while FETCH holds a request.
    task automatic test_async_reset();
        reset_dut(1'b0);
        @(negedge I_clk);
        checks++;
        if (bus.O_state !== 3'd0 || bus.O_mem_req !== 1'b1) begin
            errors++; $display("[TB] FAIL async_pre got %0d/%b want 0/1", bus.O_state, bus.O_mem_req);
        end
        #1 I_reset = 1'b1;
        #1;
        checks++;
        if (bus.O_mem_req !== 1'b0) begin
            errors++; $display("[TB] FAIL async_req got %b want 0", bus.O_mem_req);
        end
        checks++;
        if (bus.O_state !== 3'd6 || bus.O_halted !== 1'b1) begin
            errors++; $display("[TB] FAIL async_state got %0d/%b want 6/1", bus.O_state, bus.O_halted);
        end
        @(negedge I_clk);
        I_reset = 1'b0;
    endtask

    initial begin
        $display("[TB] cpu_ctrl_sequencer bench start");
        test_reset();
        test_alu_instr();
        test_load_wait();
        test_store();
        test_timeout();
        test_halt();
        test_back_to_back_perf();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
